// File: rtl/wb_single_master.sv
// Wishbone classic single-transfer initiator with a valid/ready command port and irq-driven polling.
// Latency: accept->stb same edge, response pulse the cycle after ack/timeout; commands stall (cmd_ready_o low) while busy or a poll is pending.
module wb_single_master #(
    parameter int                      WB_ADR_WIDTH   = 32,
    parameter int                      WB_DAT_WIDTH   = 32,
    parameter int                      TIMEOUT_CYCLES = 16,
    parameter logic [WB_ADR_WIDTH-1:0] POLL_ADR       = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [WB_ADR_WIDTH-1:0]   cmd_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]   cmd_dat_i,
    output logic                      rsp_valid_o,
    output logic [WB_DAT_WIDTH-1:0]   rsp_dat_o,
    output logic                      rsp_err_o,
    output logic                      rsp_poll_o,
    input  logic                      poll_en_i,
    input  logic                      irq_i,
    output logic [WB_ADR_WIDTH-1:0]   wb_adr_o,
    output logic [WB_DAT_WIDTH-1:0]   wb_dat_o,
    output logic                      wb_we_o,
    output logic [WB_DAT_WIDTH/8-1:0] wb_sel_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    input  logic                      wb_ack_i,
    input  logic [WB_DAT_WIDTH-1:0]   wb_dat_i
);

    localparam int          CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                    r_state, w_state_nxt;
    logic                      r_poll_pending, r_irq_prev, r_poll_tag, r_we;
    logic [CW-1:0]             r_cnt;
    logic [WB_ADR_WIDTH-1:0]   r_adr;
    logic [WB_DAT_WIDTH-1:0]   r_dat, r_rsp_dat;
    logic                      r_rsp_err, r_rsp_poll;
    logic                      w_irq_edge, w_accept, w_take_poll, w_ack, w_timeout, w_bus;

    assign w_irq_edge = poll_en_i & irq_i & ~r_irq_prev;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_take_poll = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        w_bus       = 1'b0;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready_o = ~r_poll_pending;
                // A pending poll takes priority over new commands
                if (r_poll_pending) begin
                    w_take_poll = 1'b1;
                    w_state_nxt = BUS;
                end else if (cmd_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                w_bus = 1'b1;
                if (wb_ack_i) begin
                    w_ack       = 1'b1;
                    w_state_nxt = RESP;
                end else if (TO_EN && (r_cnt == CNT_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign wb_cyc_o   = w_bus;
    assign wb_stb_o   = w_bus;
    assign wb_sel_o   = w_bus ? {(WB_DAT_WIDTH/8){1'b1}} : '0;
    assign wb_we_o    = r_we & w_bus;
    assign wb_adr_o   = r_adr;
    assign wb_dat_o   = r_dat;
    assign rsp_dat_o  = r_rsp_dat;
    assign rsp_err_o  = r_rsp_err;
    assign rsp_poll_o = r_rsp_poll;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_poll_pending <= 1'b0;
            r_irq_prev     <= 1'b0;
            r_poll_tag     <= 1'b0;
            r_we           <= 1'b0;
            r_cnt          <= '0;
            r_adr          <= '0;
            r_dat          <= '0;
            r_rsp_dat      <= '0;
            r_rsp_err      <= 1'b0;
            r_rsp_poll     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_irq_prev     <= irq_i;
            // A fresh edge re-arms even in the cycle the old pending poll is consumed
            r_poll_pending <= (r_poll_pending & ~w_take_poll) | w_irq_edge;
            r_cnt          <= w_bus ? r_cnt + 1'b1 : '0;
            if (w_take_poll) begin
                r_adr      <= POLL_ADR;
                r_we       <= 1'b0;
                r_poll_tag <= 1'b1;
            end else if (w_accept) begin
                r_adr      <= cmd_adr_i;
                r_dat      <= cmd_dat_i;
                r_we       <= cmd_we_i;
                r_poll_tag <= 1'b0;
            end
            if (w_ack) begin
                r_rsp_dat  <= r_we ? '0 : wb_dat_i;
                r_rsp_err  <= 1'b0;
                r_rsp_poll <= r_poll_tag;
            end else if (w_timeout) begin
                r_rsp_dat  <= '0;
                r_rsp_err  <= 1'b1;
                r_rsp_poll <= r_poll_tag;
            end
        end
    end

endmodule

// File: tb/tb_wb_single_master.sv
// Directed bench for wb_single_master: scoreboarded responses and bus transactions against a simple slave model.
module tb_wb_single_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic        rsp_valid, rsp_err, rsp_poll;
    logic [31:0] rsp_dat;
    logic        poll_en = 1'b0, irq = 1'b0;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic        wb_we, wb_cyc, wb_stb, wb_ack;
    logic [3:0]  wb_sel;
    logic        s_ack = 1'b0, f_ack = 1'b0;
    int          ack_on = 2;
    int          tests = 0, fails = 0;

    assign wb_ack = s_ack | f_ack;

    always #5 clk = ~clk;

    wb_single_master #(.WB_ADR_WIDTH(32), .WB_DAT_WIDTH(32), .TIMEOUT_CYCLES(16), .POLL_ADR(32'h40)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err), .rsp_poll_o(rsp_poll),
        .poll_en_i(poll_en), .irq_i(irq),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack), .wb_dat_i(wb_dat_i)
    );

    typedef struct { logic [31:0] dat; logic err; logic poll; } rsp_t;
    typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; int len; } bus_t;
    rsp_t exp_rsp[$];
    bus_t exp_bus[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h3C;
            32'h10:  return 32'h11;
            32'h40:  return 32'h5A5A;
            default: return 32'hDEAD0000 | a;
        endcase
    endfunction

    // Slave: acks on the ack_on-th strobe cycle (0 = never)
    int s_cnt = 0;
    always @(negedge clk) begin
        if (wb_cyc && wb_stb) begin
            s_cnt++;
            s_ack    = (ack_on != 0) && (s_cnt == ack_on);
            wb_dat_i = wb_we ? 32'h0 : slave_rd(wb_adr);
        end else begin
            s_cnt    = 0;
            s_ack    = 1'b0;
            wb_dat_i = 32'hFFFF_FFFF;
        end
    end

    // Bus monitor: one record per strobe burst
    logic        in_bus = 1'b0, b_we, b_bad;
    logic [31:0] b_adr, b_dat;
    int          b_len;
    always @(negedge clk) begin
        if (wb_cyc && wb_stb) begin
            if (!in_bus) begin
                in_bus = 1'b1; b_len = 0; b_bad = 1'b0;
                b_adr = wb_adr; b_dat = wb_dat_o; b_we = wb_we;
            end
            b_len++;
            if (wb_adr !== b_adr || wb_we !== b_we || wb_dat_o !== b_dat || wb_sel !== 4'hF) b_bad = 1'b1;
        end else if (in_bus) begin
            bus_t e;
            in_bus = 1'b0;
            check("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
            if (exp_bus.size() != 0) begin
                e = exp_bus.pop_front();
                check("bus_adr", b_adr, e.adr);
                check("bus_we", 32'(b_we), 32'(e.we));
                if (e.we) check("bus_dat", b_dat, e.dat);
                check("bus_len", 32'(b_len), 32'(e.len));
                check("bus_stable_sel", 32'(b_bad), 32'd0);
            end
        end
    end

    // Response monitor
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_t e;
            check("rsp_single_pulse", 32'(prev_rv), 32'd0);
            check("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
            if (exp_rsp.size() != 0) begin
                e = exp_rsp.pop_front();
                check("rsp_dat", rsp_dat, e.dat);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_poll", 32'(rsp_poll), 32'(e.poll));
            end
        end
        prev_rv = rsp_valid;
    end

    task automatic push_bus(input logic [31:0] adr, input logic [31:0] dat, input logic we, input int len);
        bus_t b;
        b.adr = adr; b.dat = dat; b.we = we; b.len = len;
        exp_bus.push_back(b);
    endtask

    task automatic push_rsp(input logic [31:0] dat, input logic err, input logic poll);
        rsp_t r;
        r.dat = dat; r.err = err; r.poll = poll;
        exp_rsp.push_back(r);
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_bus.size() != 0 || in_bus) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_rsp.size() + exp_bus.size()), 32'd0);
    endtask

    initial begin
        logic bad;
        int   n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", 32'(wb_cyc), 32'd0);
        check("rst_stb", 32'(wb_stb), 32'd0);
        check("rst_we", 32'(wb_we), 32'd0);
        check("rst_sel", 32'(wb_sel), 32'd0);
        check("rst_adr", wb_adr, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_poll", 32'(rsp_poll), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);

        // Write, ack on 2nd strobe cycle
        ack_on = 2;
        push_bus(32'h4, 32'hA5, 1'b1, 2);
        push_rsp(32'h0, 1'b0, 1'b0);
        do_cmd(1'b1, 32'h4, 32'hA5);
        wait_done("write_done");

        // Read with ready tracking
        push_bus(32'h0, 32'h0, 1'b0, 2);
        push_rsp(32'h3C, 1'b0, 1'b0);
        do_cmd(1'b0, 32'h0, 32'h0);
        bad = 1'b0; n = 0;
        do begin
            @(negedge clk);
            if (cmd_ready) bad = 1'b1;
            n++;
        end while (!rsp_valid && n < 20);
        check("ready_low_busy", 32'(bad), 32'd0);
        @(negedge clk);
        check("ready_after_resp", 32'(cmd_ready), 32'd1);
        wait_done("read_done");

        // Timeout, then a normal transfer
        ack_on = 0;
        push_bus(32'h8, 32'h0, 1'b0, 16);
        push_rsp(32'h0, 1'b1, 1'b0);
        do_cmd(1'b0, 32'h8, 32'h0);
        wait_done("timeout_done");
        check("rsp_err_hold", 32'(rsp_err), 32'd1);
        ack_on = 1;
        push_bus(32'hC, 32'h77, 1'b1, 1);
        push_rsp(32'h0, 1'b0, 1'b0);
        do_cmd(1'b1, 32'hC, 32'h77);
        wait_done("after_timeout_done");

        // Poll during an in-flight read, two irq edges collapse to one poll
        ack_on = 3; poll_en = 1'b1;
        push_bus(32'h10, 32'h0, 1'b0, 3);
        push_rsp(32'h11, 1'b0, 1'b0);
        push_bus(32'h40, 32'h0, 1'b0, 3);
        push_rsp(32'h5A5A, 1'b0, 1'b1);
        do_cmd(1'b0, 32'h10, 32'h0);
        irq = 1'b1;
        @(posedge clk); #1 irq = 1'b0;
        @(posedge clk); #1 irq = 1'b1;
        @(posedge clk); #1 irq = 1'b0;
        wait_done("poll_done");
        repeat (10) @(negedge clk);

        // Collision: command and irq edge in the same IDLE cycle
        ack_on = 2;
        push_bus(32'h20, 32'h99, 1'b1, 2);
        push_rsp(32'h0, 1'b0, 1'b0);
        push_bus(32'h40, 32'h0, 1'b0, 2);
        push_rsp(32'h5A5A, 1'b0, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h20; cmd_dat = 32'h99; irq = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0; irq = 1'b0;
        wait_done("collision_done");

        // Masked irq: no bus activity
        poll_en = 1'b0;
        @(negedge clk) irq = 1'b1;
        @(negedge clk) irq = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wb_cyc) bad = 1'b1;
        end
        check("masked_irq_idle", 32'(bad), 32'd0);

        // Reset mid-BUS with a pending poll, then a late ack
        ack_on = 0; poll_en = 1'b1;
        push_bus(32'h30, 32'h0, 1'b0, 3);
        do_cmd(1'b0, 32'h30, 32'h0);
        @(negedge clk) irq = 1'b1;
        @(negedge clk) irq = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("rst_mid_cyc", 32'(wb_cyc), 32'd0);
        check("rst_mid_stb", 32'(wb_stb), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        f_ack = 1'b1;
        repeat (2) @(negedge clk);
        f_ack = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wb_cyc || rsp_valid) bad = 1'b1;
        end
        check("rst_mid_quiet", 32'(bad), 32'd0);
        wait_done("final_sb_empty");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
